// File: rtl/watch_set_ctrl.sv
// watch_set_ctrl: button-driven time/date setting controller.
// Four debounced buttons drive a NORMAL/EDIT machine that walks the selected
// field and emits single-cycle inc/dec strobes (with hold-to-repeat) toward the
// datetime counter, plus edit/field/blink for the display driver.

// Per-button conditioner: 2-flop synchronizer followed by a stability counter.
module watch_set_ctrl_btn #(
    parameter int DEBOUNCE = 20,
    parameter int CW       = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press
);
    localparam int            DB_L    = (DEBOUNCE > 1) ? DEBOUNCE - 1 : 0;
    localparam logic [CW-1:0] DB_LAST = CW'(DB_L);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    // synchronize the asynchronous button input
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sync <= '0;
        else      sync <= {sync[0], raw};
    end

    // accept a new level once the synced input has disagreed for DEBOUNCE cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt >= DB_LAST) begin
                level <= sync[1];
                press <= sync[1];
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module watch_set_ctrl #(
    parameter int DEBOUNCE      = 20,
    parameter int REPEAT_DELAY  = 500,
    parameter int REPEAT_PERIOD = 100,
    parameter int IDLE_TIMEOUT  = 30000,
    parameter int BLINK_HALF    = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_next,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic       i_y,
    output logic       i_mo,
    output logic       i_d,
    output logic       i_a,
    output logic       i_h,
    output logic       i_m,
    output logic       i_s,
    output logic       d_y,
    output logic       d_mo,
    output logic       d_d,
    output logic       d_h,
    output logic       d_m,
    output logic       d_s,
    output logic       edit,
    output logic [2:0] field,
    output logic       blink
);
    localparam int NUM_BTN = 4;
    localparam int B_MODE  = 0;
    localparam int B_NEXT  = 1;
    localparam int B_UP    = 2;
    localparam int B_DOWN  = 3;

    // repeat period below 2 would violate the one-idle-cycle rule of the counter
    localparam int RPER = (REPEAT_PERIOD < 2) ? 2 : REPEAT_PERIOD;
    localparam int M1   = (DEBOUNCE > REPEAT_DELAY) ? DEBOUNCE : REPEAT_DELAY;
    localparam int M2   = (M1 > RPER) ? M1 : RPER;
    localparam int M3   = (M2 > IDLE_TIMEOUT) ? M2 : IDLE_TIMEOUT;
    localparam int MAXP = (M3 > BLINK_HALF) ? M3 : BLINK_HALF;
    localparam int CW   = $clog2(MAXP + 1);

    localparam int DL_I = (REPEAT_DELAY > 1) ? REPEAT_DELAY - 1 : 0;
    localparam int PL_I = RPER - 1;
    localparam int IL_I = (IDLE_TIMEOUT > 1) ? IDLE_TIMEOUT - 1 : 0;
    localparam int BL_I = (BLINK_HALF > 1) ? BLINK_HALF - 1 : 0;

    localparam logic [CW-1:0] DLY_LAST  = CW'(DL_I);
    localparam logic [CW-1:0] PER_LAST  = CW'(PL_I);
    localparam logic [CW-1:0] IDLE_LAST = CW'(IL_I);
    localparam logic [CW-1:0] BLK_LAST  = CW'(BL_I);
    localparam logic [CW-1:0] SUP_LOAD  = CW'(REPEAT_DELAY);
    localparam logic [2:0]    FLD_AMPM  = 3'd3;
    localparam logic [2:0]    FLD_LAST  = 3'd6;

    typedef enum logic {S_NORMAL = 1'b0, S_EDIT = 1'b1} state_t;

    logic [NUM_BTN-1:0] raw, lvl, prs;

    state_t        state_q, state_n;
    logic [2:0]    field_q, field_n;
    logic [6:0]    inc_q, inc_n;       // y, mo, d, a, h, m, s (bit 0 = year)
    logic [5:0]    dec_q, dec_n;       // y, mo, d, h, m, s
    logic          rep_act_q, rep_act_n;
    logic          rep_dn_q, rep_dn_n;
    logic          rep_first_q, rep_first_n;
    logic [CW-1:0] rep_cnt_q, rep_cnt_n;
    logic [CW-1:0] idle_q, idle_n;
    logic [CW-1:0] bcnt_q, bcnt_n;
    logic          phase_q, phase_n;
    logic [CW-1:0] sup_q, sup_n;
    logic          blink_q, blink_n;

    logic          fire, fire_dn, held, stb_busy, rep_ok;
    logic [2:0]    dec_idx;

    assign raw = {btn_down, btn_up, btn_next, btn_mode};

    genvar g;
    generate
        for (g = 0; g < NUM_BTN; g++) begin : g_btn
            watch_set_ctrl_btn #(.DEBOUNCE(DEBOUNCE), .CW(CW)) u_btn (
                .clk   (clk),
                .rst   (rst),
                .raw   (raw[g]),
                .level (lvl[g]),
                .press (prs[g])
            );
        end
    endgenerate

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + 1'b1;
    endfunction

    // register all state and outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_NORMAL;
            field_q     <= '0;
            inc_q       <= '0;
            dec_q       <= '0;
            rep_act_q   <= 1'b0;
            rep_dn_q    <= 1'b0;
            rep_first_q <= 1'b0;
            rep_cnt_q   <= '0;
            idle_q      <= '0;
            bcnt_q      <= '0;
            phase_q     <= 1'b0;
            sup_q       <= '0;
            blink_q     <= 1'b0;
        end else begin
            state_q     <= state_n;
            field_q     <= field_n;
            inc_q       <= inc_n;
            dec_q       <= dec_n;
            rep_act_q   <= rep_act_n;
            rep_dn_q    <= rep_dn_n;
            rep_first_q <= rep_first_n;
            rep_cnt_q   <= rep_cnt_n;
            idle_q      <= idle_n;
            bcnt_q      <= bcnt_n;
            phase_q     <= phase_n;
            sup_q       <= sup_n;
            blink_q     <= blink_n;
        end
    end

    // next-state: mode > next > up/down priority, repeat, idle timeout, blink
    always_comb begin
        state_n     = state_q;
        field_n     = field_q;
        inc_n       = '0;
        dec_n       = '0;
        rep_act_n   = rep_act_q;
        rep_dn_n    = rep_dn_q;
        rep_first_n = rep_first_q;
        rep_cnt_n   = sat_inc(rep_cnt_q);
        idle_n      = sat_inc(idle_q);
        bcnt_n      = bcnt_q;
        phase_n     = phase_q;
        sup_n       = (sup_q != '0) ? sup_q - 1'b1 : '0;
        fire        = 1'b0;
        fire_dn     = 1'b0;
        stb_busy    = (|inc_q) | (|dec_q);
        held        = rep_dn_q ? lvl[B_DOWN] : lvl[B_UP];
        // repeat only runs while the repeating key is the sole button held
        rep_ok      = held & ~(lvl[B_UP] & lvl[B_DOWN]) & ~lvl[B_MODE] & ~lvl[B_NEXT];
        dec_idx     = (field_q > FLD_AMPM) ? field_q - 3'd1 : field_q;

        if (rep_act_q && !held) rep_act_n = 1'b0;

        case (state_q)
            S_NORMAL: begin
                rep_act_n = 1'b0;
                idle_n    = '0;
                bcnt_n    = '0;
                phase_n   = 1'b0;
                if (prs[B_MODE]) begin
                    state_n = S_EDIT;
                    field_n = '0;
                end
            end
            S_EDIT: begin
                if (bcnt_q >= BLK_LAST) begin
                    bcnt_n  = '0;
                    phase_n = ~phase_q;
                end else begin
                    bcnt_n = bcnt_q + 1'b1;
                end

                if (prs[B_MODE]) begin
                    state_n   = S_NORMAL;
                    rep_act_n = 1'b0;
                    idle_n    = '0;
                end else if (prs[B_NEXT]) begin
                    field_n   = (field_q >= FLD_LAST) ? 3'd0 : field_q + 3'd1;
                    rep_act_n = 1'b0;
                    idle_n    = '0;
                end else if (prs[B_UP] || prs[B_DOWN]) begin
                    idle_n = '0;
                    if ((prs[B_UP] != prs[B_DOWN]) && !stb_busy) begin
                        fire        = 1'b1;
                        fire_dn     = prs[B_DOWN];
                        rep_act_n   = 1'b1;
                        rep_dn_n    = prs[B_DOWN];
                        rep_first_n = 1'b1;
                        rep_cnt_n   = '0;
                    end else begin
                        rep_act_n = 1'b0;
                    end
                end else if (rep_act_q && rep_ok && !stb_busy &&
                             (rep_cnt_q >= (rep_first_q ? DLY_LAST : PER_LAST))) begin
                    fire        = 1'b1;
                    fire_dn     = rep_dn_q;
                    rep_first_n = 1'b0;
                    rep_cnt_n   = '0;
                    idle_n      = '0;
                end else if (idle_q >= IDLE_LAST) begin
                    state_n   = S_NORMAL;
                    rep_act_n = 1'b0;
                end
            end
            default: begin
                state_n = S_NORMAL;
            end
        endcase

        // AMPM has no decrement input; down toggles it through i_a
        if (fire) begin
            if (!fire_dn || field_q == FLD_AMPM) inc_n[field_q] = 1'b1;
            else                                 dec_n[dec_idx] = 1'b1;
            sup_n = SUP_LOAD;
        end

        blink_n = (state_n == S_EDIT) && phase_n && (sup_n == '0);
    end

    assign {i_s, i_m, i_h, i_a, i_d, i_mo, i_y} = inc_q;
    assign {d_s, d_m, d_h, d_d, d_mo, d_y}      = dec_q;
    assign edit  = (state_q == S_EDIT);
    assign field = field_q;
    assign blink = blink_q;
endmodule
